seg_scan_driver: RTL and testbench

- Downstream display stage for the traffic-light controller.
- Latches a phase code and a 0..15 countdown value on an update strobe. Converts the count to two decimal digits with tens blanking.
- Time-multiplexes three digits of the board's 8-digit common-anode 7-segment display: phase letter on digit 3, tens on digit 1, ones on digit 0.
- Segment and enable outputs are registered and drive the board pins directly.

---
 rtl/seg_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Three-digit scan driver for a common-anode 7-segment board: phase letter on digit 3, count tens/ones on digits 1/0.
// Optional blink of the yellow phase is enabled by defining SEG_SCAN_DRIVER_BLINK_EN.
module seg_scan_driver #(
  parameter int SCAN_DIV    = 20000,
  parameter int BLINK_TICKS = 512
) (
  input  logic       clk,
  input  logic       start,
  input  logic       upd,
  input  logic [1:0] phase,
  input  logic [3:0] count,
  output logic [7:0] light,
  output logic [7:0] lightControl
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink_ticks
    $error("seg_scan_driver: BLINK_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    SLOT_PHASE = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_ONES  = 2'd2
  } slot_t;

  slot_t            r_slot;
  slot_t            w_slot_nxt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_phase;
  logic [3:0]       r_count;
  logic             w_tick;
  logic             w_ge10;
  logic [3:0]       w_ones;
  logic [6:0]       w_glyph;
  logic [7:0]       w_ctrl;
  logic             w_blank;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'h40;
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] phase_glyph(input logic [1:0] p);
    case (p)
      2'd0:    phase_glyph = 7'h42;
      2'd1:    phase_glyph = 7'h11;
      2'd2:    phase_glyph = 7'h2F;
      default: phase_glyph = 7'h3F;
    endcase
  endfunction

  assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_ge10 = (r_count >= 4'd10);
  assign w_ones = w_ge10 ? (r_count - 4'd10) : r_count;

  always_ff @(posedge clk) begin
    if (!start) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Non-blocking latch: a tick on the same edge still sees the previous phase/count.
  always_ff @(posedge clk) begin
    if (!start) begin
      r_phase <= 2'd3;
      r_count <= 4'd0;
    end else if (upd) begin
      r_phase <= phase;
      r_count <= count;
    end
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      r_slot <= SLOT_PHASE;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  always_comb begin
    w_slot_nxt = r_slot;
    w_ctrl     = 8'hFF;
    w_glyph    = 7'h7F;
    case (r_slot)
      SLOT_PHASE: begin
        w_ctrl  = 8'b1111_0111;
        w_glyph = phase_glyph(r_phase);
        if (w_tick) w_slot_nxt = SLOT_TENS;
      end
      SLOT_TENS: begin
        w_ctrl  = 8'b1111_1101;
        w_glyph = w_ge10 ? digit_glyph(4'd1) : 7'h7F;
        if (w_tick) w_slot_nxt = SLOT_ONES;
      end
      SLOT_ONES: begin
        w_ctrl  = 8'b1111_1110;
        w_glyph = digit_glyph(w_ones);
        if (w_tick) w_slot_nxt = SLOT_PHASE;
      end
      default: begin
        w_slot_nxt = SLOT_PHASE;
      end
    endcase
  end

`ifdef SEG_SCAN_DRIVER_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [BW-1:0] r_bcnt;
  logic          r_blink_off;

  // Entering yellow restarts the blink lit; any other phase keeps it idle.
  always_ff @(posedge clk) begin
    if (!start) begin
      r_bcnt      <= '0;
      r_blink_off <= 1'b0;
    end else if ((upd && (phase == 2'd1) && (r_phase != 2'd1)) || (r_phase != 2'd1)) begin
      r_bcnt      <= '0;
      r_blink_off <= 1'b0;
    end else if (w_tick) begin
      if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
        r_bcnt      <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // Gating by phase stops the blink on the first tick after leaving yellow.
  assign w_blank = r_blink_off & (r_phase == 2'd1);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!start) begin
      light        <= 8'hFF;
      lightControl <= 8'hFF;
    end else if (w_tick) begin
      light        <= w_blank ? 8'hFF : {1'b0, w_glyph};
      lightControl <= w_ctrl;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: spec-level scan model compared every cycle, plus literal tick checks.
// Handshake note: upd is a plain one-cycle strobe, no ready; inputs change on negedge only.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BT = 2;

  logic       clk = 1'b0;
  logic       start;
  logic       upd;
  logic [1:0] phase;
  logic [3:0] count;
  logic [7:0] light;
  logic [7:0] lightControl;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .start(start), .upd(upd), .phase(phase), .count(count),
    .light(light), .lightControl(lightControl)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: ticks are every SD-th cycle after reset, slots rotate by tick index
  logic [7:0] dig_tab [10] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78, 8'h00, 8'h10};
  logic [7:0] ph_tab  [4]  = '{8'h42, 8'h11, 8'h2F, 8'h3F};
  logic [7:0] ctl_tab [3]  = '{8'hF7, 8'hFD, 8'hFE};

  logic       m_valid = 1'b0;
  int         m_cyc, m_ticks, m_slot_last, m_bcnt;
  bit         m_ticked, m_boff;
  int         m_ph, m_cnt;
  logic [7:0] exp_light, exp_ctrl;
  logic [15:0] exp_q[$];

  function automatic logic [7:0] glyph_of(int slot, int ph, int cnt);
    if (slot == 0) return ph_tab[ph];
    if (slot == 1) return (cnt >= 10) ? dig_tab[1] : 8'h7F;
    return dig_tab[cnt % 10];
  endfunction

  always @(posedge clk) begin
    m_ticked = 1'b0;
    if (!start) begin
      m_valid = 1'b1; m_cyc = 0; m_ticks = 0; m_ph = 3; m_cnt = 0;
      m_bcnt = 0; m_boff = 1'b0; exp_light = 8'hFF; exp_ctrl = 8'hFF;
      exp_q.delete();
    end else begin
      if (m_cyc % SD == SD - 1) begin
        m_slot_last = m_ticks % 3;
        exp_ctrl  = ctl_tab[m_slot_last];
        exp_light = glyph_of(m_slot_last, m_ph, m_cnt);
`ifdef SEG_SCAN_DRIVER_BLINK_EN
        if (m_ph == 1 && m_boff) exp_light = 8'hFF;
        if (m_ph == 1) begin
          m_bcnt++;
          if (m_bcnt == BT) begin m_bcnt = 0; m_boff = !m_boff; end
        end
`endif
        m_ticks++;
        m_ticked = 1'b1;
        exp_q.push_back({exp_ctrl, exp_light});
      end
      m_cyc++;
      if (upd) begin
`ifdef SEG_SCAN_DRIVER_BLINK_EN
        if (phase == 2'd1 && m_ph != 1) begin m_bcnt = 0; m_boff = 1'b0; end
`endif
        m_ph  = int'(phase);
        m_cnt = int'(count);
      end
`ifdef SEG_SCAN_DRIVER_BLINK_EN
      if (m_ph != 1) begin m_bcnt = 0; m_boff = 1'b0; end
`endif
    end
  end

  // scoreboard: every cycle against the model, and each new frame against the expected queue
  always @(negedge clk) begin
    logic [15:0] q_item;
    if (m_valid) begin
      n_vec++;
      if (light !== exp_light || lightControl !== exp_ctrl) begin
        n_err++;
        $display("FAIL cycle_model t=%0t light=%h ctrl=%h expected light=%h ctrl=%h",
                 $time, light, lightControl, exp_light, exp_ctrl);
      end
      if (m_ticked && exp_q.size() > 0) begin
        q_item = exp_q.pop_front();
        n_vec++;
        if ({lightControl, light} !== q_item) begin
          n_err++;
          $display("FAIL frame_queue t=%0t got=%h expected=%h", $time, {lightControl, light}, q_item);
        end
      end
    end
  end

  // driver tasks
  task automatic check_lit(input string name, input logic [7:0] c, input logic [7:0] l);
    n_vec++;
    if (lightControl !== c || light !== l) begin
      n_err++;
      $display("FAIL %s ctrl=%h light=%h expected ctrl=%h light=%h", name, lightControl, light, c, l);
    end
  endtask

  task automatic wait_slot(input int s);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_ticked && m_slot_last == s) found = 1'b1;
    end
    if (!found) begin
      n_err++;
      $display("FAIL wait_slot%0d timeout", s);
    end
  endtask

  task automatic do_upd(input logic [1:0] p, input logic [3:0] c);
    upd = 1'b1; phase = p; count = c;
    @(negedge clk);
    upd = 1'b0;
  endtask

  logic [7:0] blink_tab [6];

  initial begin
`ifdef SEG_SCAN_DRIVER_BLINK_EN
    blink_tab = '{8'h11, 8'h7F, 8'hFF, 8'h42, 8'h7F, 8'h30};
`else
    blink_tab = '{8'h11, 8'h7F, 8'h30, 8'h42, 8'h7F, 8'h30};
`endif
    start = 1'b0; upd = 1'b0; phase = 2'd0; count = 4'd0;
    repeat (5) @(negedge clk);
    check_lit("reset", 8'hFF, 8'hFF);
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_lit("pre_first_tick", 8'hFF, 8'hFF);
    @(negedge clk);
    check_lit("first_tick_dash", 8'hF7, 8'h3F);

    do_upd(2'd0, 4'd12);
    wait_slot(0); check_lit("c12_slot0", 8'hF7, 8'h42);
    wait_slot(1); check_lit("c12_slot1", 8'hFD, 8'h79);
    wait_slot(2); check_lit("c12_slot2", 8'hFE, 8'h24);
    wait_slot(0); check_lit("c12_repeat", 8'hF7, 8'h42);

    do_upd(2'd2, 4'd7);
    wait_slot(0); check_lit("c7_slot0", 8'hF7, 8'h2F);
    wait_slot(1); check_lit("c7_tens_blank", 8'hFD, 8'h7F);
    wait_slot(2); check_lit("c7_slot2", 8'hFE, 8'h78);
    do_upd(2'd2, 4'd0);
    wait_slot(1); check_lit("c0_tens_blank", 8'hFD, 8'h7F);
    wait_slot(2); check_lit("c0_ones", 8'hFE, 8'h40);

    // upd lands on the same edge as the slot2 tick
    do_upd(2'd0, 4'd3);
    wait_slot(0);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
        if (m_cyc % SD == SD - 1 && m_ticks % 3 == 2) found = 1'b1;
        else @(negedge clk);
      end
      if (!found) begin n_err++; $display("FAIL simul_align timeout"); end
    end
    do_upd(2'd0, 4'd15);
    check_lit("simul_old", 8'hFE, 8'h30);
    wait_slot(2); check_lit("simul_new", 8'hFE, 8'h12);

    // mid-scan reset during slot1
    wait_slot(1);
    start = 1'b0;
    @(negedge clk);
    check_lit("mid_reset", 8'hFF, 8'hFF);
    start = 1'b1;
    wait_slot(0); check_lit("restart_slot0", 8'hF7, 8'h3F);

    // yellow blink (or steady glyphs without the feature), then back to green
    do_upd(2'd0, 4'd3);
    wait_slot(2);
    do_upd(2'd1, 4'd3);
    for (int k = 0; k < 6; k++) begin
      wait_slot(k % 3);
      check_lit($sformatf("blink_%0d", k), ctl_tab[k % 3], blink_tab[k]);
      if (k == 2) do_upd(2'd0, 4'd3);
    end

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        start = 1'b1;
      end
      upd   = ($urandom_range(0, 7) == 0);
      phase = 2'($urandom_range(0, 3));
      count = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    upd = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
